// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, 64-word ROM addressing and a DEPTH-entry
// {instr, pc} buffer handed to decode over valid/ready. Optional halt detection: FETCH_HALT_EN.
module fetch_unit #(
    parameter int          N         = 64,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hb400001f
) (
    input  logic         clk,
    input  logic         reset,
    output logic [5:0]   imem_addr,
    input  logic [31:0]  imem_q,
    input  logic         redirect_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic [31:0]  instr_o,
    output logic [N-1:0] pc_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         halted_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   pc_reg, pc_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PW:0]    count_reg, count_next;

    logic           pop;
    logic           push;
    logic           hit_halt;

    logic [31:0]    entry_instr [DEPTH];
    logic [N-1:0]   entry_pc    [DEPTH];

    assign pop  = (count_reg != '0) && ready_i;
    assign push = (state_reg == FETCH) && !redirect_i && ((count_reg < FULL_COUNT) || pop);

`ifdef FETCH_HALT_EN
    assign hit_halt = push && (imem_q == HALT_WORD);
    assign halted_o = (state_reg == HALT);
`else
    assign hit_halt = 1'b0;
    assign halted_o = 1'b0;
`endif

    // Word address is a plain slice of the PC, so it wraps 63->0 along with pc[7:2].
    assign imem_addr = pc_reg[7:2];

    assign valid_o = (count_reg != '0);
    assign instr_o = entry_instr[rd_ptr_reg];
    assign pc_o    = entry_pc[rd_ptr_reg];

    // Buffer storage: one register pair per slot, written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0]  instr_reg;
            logic [N-1:0] epc_reg;
            logic         wr_sel;

            assign wr_sel = push && (wr_ptr_reg == PW'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    instr_reg <= '0;
                    epc_reg   <= '0;
                end else if (wr_sel) begin
                    instr_reg <= imem_q;
                    epc_reg   <= pc_reg;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_pc[gi]    = epc_reg;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (redirect_i) begin
            // Redirect wins over everything, including a handshake completing this cycle.
            state_next  = FETCH;
            pc_next     = {redirect_pc_i[N-1:2], 2'b00};
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
                pc_next     = pc_reg + N'(4);
            end
            if (push && !pop) begin
                count_next = count_reg + (PW+1)'(1);
            end else if (pop && !push) begin
                count_next = count_reg - (PW+1)'(1);
            end
            if (hit_halt) begin
                state_next = HALT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= FETCH;
            pc_reg     <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed phases plus random ready/redirect traffic,
// compared each cycle against a queue-based model of the fetch buffer and PC.
module tb_fetch_unit;

    localparam int          N         = 64;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] HALT_WORD = 32'hb400001f;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [5:0]   imem_addr;
    logic [31:0]  imem_q;
    logic         redirect_i;
    logic [N-1:0] redirect_pc_i;
    logic [31:0]  instr_o;
    logic [N-1:0] pc_o;
    logic         valid_o;
    logic         ready_i;
    logic         halted_o;

    logic [31:0] rom [64];
    assign imem_q = rom[imem_addr];

    fetch_unit #(.N(N), .DEPTH(DEPTH), .HALT_WORD(HALT_WORD)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_q       (imem_q),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .halted_o     (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  instr;
        logic [N-1:0] pc;
    } ent_t;

    ent_t         model_q[$];
    logic [N-1:0] model_pc;
    bit           model_halt;
    int           errors = 0;
    int           checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance model, return at next posedge+1.
    task automatic step(input bit rdy, input bit redir, input logic [N-1:0] tgt);
        bit          do_pop;
        bit          do_push;
        logic [31:0] word;
        ent_t        e;
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        @(negedge clk);
        check_eq("valid", 64'(valid_o), 64'(model_q.size() != 0));
        check_eq("imem_addr", 64'(imem_addr), 64'(model_pc[7:2]));
        check_eq("halted", 64'(halted_o), 64'(model_halt));
        if (model_q.size() != 0) begin
            check_eq("instr", 64'(instr_o), 64'(model_q[0].instr));
            check_eq("pc", pc_o, model_q[0].pc);
        end
        do_pop = (model_q.size() != 0) && rdy;
        if (redir) begin
            $display("redirect target=%h", tgt);
            model_q.delete();
            model_pc   = {tgt[N-1:2], 2'b00};
            model_halt = 1'b0;
        end else begin
            do_push = !model_halt && ((model_q.size() < DEPTH) || do_pop);
            word    = rom[model_pc[7:2]];
            if (do_pop) begin
                $display("pop pc=%h instr=%h", model_q[0].pc, model_q[0].instr);
                void'(model_q.pop_front());
            end
            if (do_push) begin
                e.instr = word;
                e.pc    = model_pc;
                model_q.push_back(e);
                model_pc = model_pc + 64'd4;
                if (HALT_EN && word == HALT_WORD) model_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_check();
        #1;
        reset = 1'b1;
        #1;
        $display("async reset asserted mid-cycle");
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_imem_addr", 64'(imem_addr), 64'd0);
        check_eq("rst_halted", 64'(halted_o), 64'd0);
        check_eq("rst_pc_o", pc_o, 64'd0);
        model_q.delete();
        model_pc   = '0;
        model_halt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = 32'h1000_0000 + k;
        rom[3] = HALT_WORD;
        model_pc      = '0;
        model_halt    = 1'b0;
        reset         = 1'b1;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        #3;
        check_eq("reset_valid", 64'(valid_o), 64'd0);
        check_eq("reset_imem_addr", 64'(imem_addr), 64'd0);
        check_eq("reset_halted", 64'(halted_o), 64'd0);
        check_eq("reset_pc_o", pc_o, 64'd0);
        check_eq("reset_instr_o", 64'(instr_o), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Stall from reset, then stream.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0);

        // Reach pc=0x40, then redirect to the misaligned target 0x13.
        step(1'b1, 1'b1, 64'h20);
        for (int i = 0; i < 40; i++) begin
            if (model_pc == 64'h40) break;
            step(1'b1, 1'b0, '0);
        end
        check_eq("reach_0x40", model_pc, 64'h40);
        step(1'b1, 1'b1, 64'h13);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // Address wrap past 0xFC.
        step(1'b1, 1'b1, 64'hF0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 {$urandom, $urandom});
        end

        // Fill the buffer, then reset asynchronously and resume.
        step(1'b0, 1'b1, 64'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        async_reset_check();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the LEGv8 single-cycle/pipelined datapath. It owns the program counter, drives the word address into the 64-word instruction ROM, and captures each returned 32-bit instruction with its PC into a small buffer. The buffer feeds the decode stage through a valid/ready handshake. Control-flow changes arrive as redirects, which flush the buffer and reload the PC.

## Interface
- N, 64, PC width in bits
- DEPTH, 2, buffer entries (power of two, ≥2)
- HALT_WORD, 32'hb400001f, halt instruction encoding (CBZ XZR, #0); used only with FETCH_HALT_EN
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_addr  out  6  ROM word address = pc[7:2]
- imem_q  in  32  ROM data; combinational from imem_addr, same cycle
- redirect_i  in  1  load new PC and flush buffer
- redirect_pc_i  in  N  redirect target; bits [1:0] ignored and forced to 0
- instr_o  out  32  instruction at buffer head
- pc_o  out  N  PC of instr_o
- valid_o  out  1  buffer head holds a valid entry
- ready_i  in  1  decode accepts head this cycle
- halted_o  out  1  fetch stopped on HALT_WORD (tied 0 without FETCH_HALT_EN)

## Operation
- State: pc (N bits), circular buffer of DEPTH {instr, pc} entries, rd/wr pointers, count (0..DEPTH), FSM {FETCH, HALT}.
- Reset values: pc=0, count=0, pointers=0, FSM=FETCH. Outputs: valid_o=0, halted_o=0, imem_addr=0. instr_o and pc_o show entry 0, which resets to 0.
- Pop = valid_o & ready_i.
- Push = FSM==FETCH & !redirect_i & (count<DEPTH | pop).
- On push:
  - write {imem_q, pc} at wr pointer.
  - pc <= pc+4, modulo 2^N.
  - imem_addr wraps 63→0.
- count update:
  - push & !pop: +1
  - pop & !push: −1
  - both or neither: unchanged
- Redirect has the highest priority:
  - pc <= {redirect_pc_i[N-1:2],2'b00}
  - count <= 0; pointers <= 0
  - FSM <= FETCH
  - No push that cycle. A handshake completing in the same cycle is discarded.
- valid_o = (count != 0). instr_o and pc_o come from the rd pointer. Both are stable while valid_o & !ready_i.
- Full buffer with ready_i=0: pc holds and imem_addr holds. No entry is lost or duplicated.
- Asserting reset mid-operation returns everything to reset values immediately (asynchronous). Buffered entries are discarded.

## Timing
- First push on the first rising edge after reset deasserts. valid_o=1 from that edge, with pc_o=0.
- Fetch-to-decode latency: 1 cycle (ROM read in cycle t, entry visible at head in t+1 if the buffer was empty).
- Sustained throughput: 1 instruction/cycle while ready_i=1.
- Redirect at edge t:
  - valid_o=0 in cycle t+1, with imem_addr = target[7:2].
  - Target instruction valid from t+2.
- All outputs are registered except imem_addr, which is a direct slice of the pc register.

## Configuration
- FETCH_HALT_EN defined:
  - When a pushed imem_q equals HALT_WORD, the entry is still pushed and FSM goes FETCH→HALT on that edge.
  - In HALT, pushes stop and pc freezes at the halt PC+4.
  - halted_o=1 while in HALT.
  - The buffer still drains normally.
  - Only reset or redirect_i leaves HALT.
- FETCH_HALT_EN undefined:
  - No HALT state; HALT_WORD is fetched like any other word.
  - halted_o tied to 0.

## Test plan
- Reset, ROM model with word k = 32'h1000_0000+k, ready_i=1 → pc_o 0,4,8,… and instr_o 10000000,10000001,… on consecutive cycles; valid_o=1 from the first edge.
- Hold ready_i=0 for 5 cycles from reset → count saturates at 2 and imem_addr stays at 2. Release → heads pc 0,4,8 in order with no gaps or duplicates.
- At pc=0x40, redirect_i=1 with redirect_pc_i=0x13 → next cycle valid_o=0 and imem_addr=4. Following cycle pc_o=0x10.
- Fetch through pc=0xFC → imem_addr wraps 63→0 while pc_o=0x100.
- FETCH_HALT_EN, word 3 = 32'hb400001f → entries pc 0..0xC delivered; halted_o=1 after edge 4; pc stays 0x10; redirect to 0 resumes fetch and clears halted_o.
- Assert reset while the buffer is full → valid_o=0, imem_addr=0, halted_o=0 immediately, without waiting for a clock edge.
